// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter onto one 64-bit Avalon-MM SDRAM port.
// Ports: clock/reset; p0_*/p1_* requester slaves; sd_* SDRAM master; debug_value status.
module sdram_arbiter #(
  parameter int TRACK_DEPTH = 8,
  parameter int TRACK_AW    = 3
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [28:0] p0_address,
  input  logic [7:0]  p0_burstcount,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [63:0] p0_writedata,
  input  logic [7:0]  p0_byteenable,
  output logic        p0_waitrequest,
  output logic [63:0] p0_readdata,
  output logic        p0_readdatavalid,

  input  logic [28:0] p1_address,
  input  logic [7:0]  p1_burstcount,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [63:0] p1_writedata,
  input  logic [7:0]  p1_byteenable,
  output logic        p1_waitrequest,
  output logic [63:0] p1_readdata,
  output logic        p1_readdatavalid,

  output logic [28:0] sd_address,
  output logic [7:0]  sd_burstcount,
  output logic        sd_read,
  output logic        sd_write,
  output logic [63:0] sd_writedata,
  output logic [7:0]  sd_byteenable,
  input  logic        sd_waitrequest,
  input  logic [63:0] sd_readdata,
  input  logic        sd_readdatavalid,

  output logic [31:0] debug_value
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    WBURST = 2'd2
  } state_t;

  localparam logic [TRACK_AW:0] FULL_CNT =
    (TRACK_AW+1)'(TRACK_DEPTH);

  state_t state;
  state_t state_nx;

  logic grant;
  logic grant_nx;
  logic last_grant;
  logic last_grant_nx;
  logic [7:0] beats_left;
  logic [7:0] beats_left_nx;

  // Granted-port view of the request bus
  logic [28:0] g_address;
  logic [7:0]  g_burst;
  logic [7:0]  g_bc;
  logic        g_read;
  logic        g_write;
  logic [63:0] g_wdata;
  logic [7:0]  g_be;

  assign g_address = grant ? p1_address    : p0_address;
  assign g_burst   = grant ? p1_burstcount : p0_burstcount;
  assign g_read    = grant ? p1_read       : p0_read;
  assign g_write   = grant ? p1_write      : p0_write;
  assign g_wdata   = grant ? p1_writedata  : p0_writedata;
  assign g_be      = grant ? p1_byteenable : p0_byteenable;
  assign g_bc      = (g_burst == 8'd0) ? 8'd1 : g_burst;

  assign sd_address    = g_address;
  assign sd_burstcount = g_bc;
  assign sd_writedata  = g_wdata;
  assign sd_byteenable = g_be;

  // Outstanding-read tracking FIFO: {port id, burst length}
  logic                fifo_id  [TRACK_DEPTH];
  logic [7:0]          fifo_len [TRACK_DEPTH];
  logic [TRACK_AW-1:0] wr_ptr;
  logic [TRACK_AW-1:0] rd_ptr;
  logic [TRACK_AW:0]   count;
  logic [7:0]          head_beats;
  logic [15:0]         orphan_count;

  logic empty;
  logic full;
  logic head_id;
  logic [7:0] head_len;
  logic beat;
  logic pop;
  logic push;
  logic room;
  logic elig0;
  logic elig1;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign head_id  = fifo_id[rd_ptr];
  assign head_len = fifo_len[rd_ptr];
  assign beat     = sd_readdatavalid & ~empty;
  assign pop      = beat & (head_beats == head_len - 8'd1);

  // A pop in this cycle frees the slot a new read would need.
  assign room  = ~full | pop;
  assign elig0 = p0_write | (p0_read & room);
  assign elig1 = p1_write | (p1_read & room);

  assign p0_readdata      = sd_readdata;
  assign p1_readdata      = sd_readdata;
  assign p0_readdatavalid = beat & ~head_id;
  assign p1_readdatavalid = beat & head_id;

  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    last_grant_nx  = last_grant;
    beats_left_nx  = beats_left;
    push           = 1'b0;
    sd_read        = 1'b0;
    sd_write       = 1'b0;
    p0_waitrequest = 1'b1;
    p1_waitrequest = 1'b1;

    unique case (state)
      IDLE: begin
        if (elig0 && elig1) begin
          grant_nx = ~last_grant;
          state_nx = CMD;
        end else if (elig0) begin
          grant_nx = 1'b0;
          state_nx = CMD;
        end else if (elig1) begin
          grant_nx = 1'b1;
          state_nx = CMD;
        end
      end

      CMD: begin
        // A port asserting both strobes is treated as a read.
        sd_read  = g_read;
        sd_write = g_write & ~g_read;
        if (grant) p1_waitrequest = sd_waitrequest;
        else       p0_waitrequest = sd_waitrequest;

        if (!g_read && !g_write) begin
          state_nx = IDLE;
        end else if (!sd_waitrequest) begin
          if (g_read) begin
            push          = 1'b1;
            last_grant_nx = grant;
            state_nx      = IDLE;
          end else if (g_bc == 8'd1) begin
            last_grant_nx = grant;
            state_nx      = IDLE;
          end else begin
            beats_left_nx = g_bc - 8'd1;
            state_nx      = WBURST;
          end
        end
      end

      WBURST: begin
        sd_write = g_write;
        if (grant) p1_waitrequest = sd_waitrequest;
        else       p0_waitrequest = sd_waitrequest;

        if (g_write && !sd_waitrequest) begin
          beats_left_nx = beats_left - 8'd1;
          if (beats_left == 8'd1) begin
            last_grant_nx = grant;
            state_nx      = IDLE;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beats_left <= 8'd0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      beats_left <= beats_left_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_id[wr_ptr]  <= grant;
      fifo_len[wr_ptr] <= g_bc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      head_beats   <= 8'd0;
      orphan_count <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop)       head_beats <= 8'd0;
      else if (beat) head_beats <= head_beats + 8'd1;

      if (sd_readdatavalid && empty && orphan_count != 16'hFFFF)
        orphan_count <= orphan_count + 16'd1;
    end
  end

  assign debug_value = {state, grant, last_grant, 6'(count),
                        6'b0, orphan_count};

endmodule
